mul_addtree_pipe: RTL and testbench

- Parametrised unsigned W x W multiplier built from W shifted partial products, reduced by a pipelined binary adder tree with one register level per tree level.
- Next-generation, stream-capable multiplier for the arithmetic datapath.
- Adds width/depth generalisation, a valid sideband, a clock-enable stall, and an optional multiply-accumulate output stage.

---
 rtl/mul_addtree_pipe.sv | 99 +++++++++
 tb/tb_mul_addtree_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_addtree_pipe.sv
// -----------------------------------------------------------------------------
// mul_addtree_pipe
//   Unsigned W x W multiplier. The W shifted partial products are reduced by
//   a pipelined binary adder tree that has one register level per tree level.
//   Latency is LAT = clog2(W) enabled cycles. The block accepts one operand
//   pair per enabled cycle. A valid sideband travels through the pipeline with
//   the data. A clock enable stalls the whole pipeline.
//
//   Optional feature macro: MUL_ADDTREE_ACC_EN
//     When it is defined, a (2W+8)-bit multiply-accumulate register is added.
//     It is fed by the out/out_valid beat stream.
//
// Ports
//   clk        in   1       clock, rising edge
//   clr        in   1       asynchronous active-low reset
//   ce         in   1       clock enable; 0 freezes the data and valid pipeline
//   in_valid   in   1       x/y qualify this cycle
//   x, y       in   W       unsigned operands
//   out_valid  out  1       out holds a valid product
//   out        out  2W      product x*y
//   acc_clr    in   1       accumulator restart   (MUL_ADDTREE_ACC_EN only)
//   acc        out  2W+8    running accumulation  (MUL_ADDTREE_ACC_EN only)
// -----------------------------------------------------------------------------
module mul_addtree_pipe #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             out_valid,
  output logic [2*W-1:0]   out
`ifdef MUL_ADDTREE_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [2*W+7:0]   acc
`endif
);

  localparam int LAT = $clog2(W);

  // The tree uses heap numbering. Node i has the children 2i and 2i+1.
  // Leaves W..2W-1 are the combinational partial products.
  // Nodes 1..W-1 are the registered sums.
  // W is a power of two, so every leaf sits at the same depth. Every path
  // from a leaf to the root therefore passes through exactly LAT registers.
  // Node 1 is the root and is the final product.
  logic [2*W-1:0] sum_reg [1:W-1];
  logic [2*W-1:0] node    [2:2*W-1];
  logic [LAT-1:0] vld_reg;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_leaf
      assign node[W+gi] = y[gi] ? ({{W{1'b0}}, x} << gi) : '0;
    end
    for (gi = 2; gi < W; gi++) begin : g_inner
      assign node[gi] = sum_reg[gi];
    end
  endgenerate

  // Every sum is 2W bits wide. No sum can exceed the full product, so
  // none of these sums can overflow.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 1; i < W; i++) sum_reg[i] <= '0;
      vld_reg <= '0;
    end else if (ce) begin
      for (int i = 1; i < W; i++) sum_reg[i] <= node[2*i] + node[2*i+1];
      vld_reg <= (vld_reg << 1) | LAT'(in_valid);
    end
  end

  assign out       = sum_reg[1];
  assign out_valid = vld_reg[LAT-1];

`ifdef MUL_ADDTREE_ACC_EN
  logic [2*W+7:0] acc_reg;

  // acc_clr on a valid beat restarts the sum with that beat's product.
  // acc_clr without a beat clears the sum to zero.
  // The sum wraps silently once the 8 guard bits are used up.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc_reg <= '0;
    end else if (ce) begin
      if (out_valid)
        acc_reg <= (acc_clr ? '0 : acc_reg) + {8'd0, out};
      else if (acc_clr)
        acc_reg <= '0;
    end
  end

  assign acc = acc_reg;
`endif

endmodule

// File: tb/tb_mul_addtree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mul_addtree_pipe
//   Directed bench for mul_addtree_pipe. It instantiates two copies, one with
//   W=4 and one with W=8.
//   Each issued operand pair pushes a hand-computed product and the cycle in
//   which that product is due. Per-instance monitors pop and compare these
//   entries on every new out_valid beat.
//   Stall, reset and accumulator checks are made inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_mul_addtree_pipe;

  localparam int LAT4 = 2;
  localparam int LAT8 = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b1;

  logic        ce4 = 1'b1, iv4 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic        ov4;
  logic [7:0]  out4;

  logic        ce8 = 1'b1, iv8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        ov8;
  logic [15:0] out8;

`ifdef MUL_ADDTREE_ACC_EN
  logic        acc_clr4 = 1'b0;
  logic [15:0] acc4;
  int          acc_exp [10] = '{0, 0, 0, 225, 450, 675, 900, 900, 900, 4};
`endif

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic ce4_q = 1'b0;
  logic ce8_q = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ce4_q <= ce4;
    ce8_q <= ce8;
  end

  mul_addtree_pipe #(.W(4)) dut4 (
    .clk       (clk),
    .clr       (clr),
    .ce        (ce4),
    .in_valid  (iv4),
    .x         (x4),
    .y         (y4),
    .out_valid (ov4),
    .out       (out4)
`ifdef MUL_ADDTREE_ACC_EN
    ,
    .acc_clr   (acc_clr4),
    .acc       (acc4)
`endif
  );

  mul_addtree_pipe #(.W(8)) dut8 (
    .clk       (clk),
    .clr       (clr),
    .ce        (ce8),
    .in_valid  (iv8),
    .x         (x8),
    .y         (y8),
    .out_valid (ov8),
    .out       (out8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // A beat is new only if the preceding edge was enabled. A stall cycle
  // shows the same held beat again.
  always @(negedge clk) begin
    if (clr && ce4_q && ov4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL w4_unexpected_beat: out=%0d, expected no beat (cycle %0d)", out4, cyc);
      end else begin : pop4
        exp_t e;
        e = q4.pop_front();
        check("w4_out", 32'(out4), 32'(e.val));
        check("w4_due_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (clr && ce8_q && ov8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL w8_unexpected_beat: out=%0d, expected no beat (cycle %0d)", out8, cyc);
      end else begin : pop8
        exp_t e;
        e = q8.pop_front();
        check("w8_out", 32'(out8), 32'(e.val));
        check("w8_due_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic send4(input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] expv, input int stall);
    @(negedge clk);
    ce4 = 1'b1; iv4 = 1'b1; x4 = a; y4 = b;
    q4.push_back('{val: expv, due: cyc + LAT4 + stall});
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(negedge clk);
      ce4 = 1'b1; iv4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom);
    end
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] expv);
    @(negedge clk);
    ce8 = 1'b1; iv8 = 1'b1; x8 = a; y8 = b;
    q8.push_back('{val: expv, due: cyc + LAT8});
  endtask

  task automatic idle8(input int n);
    repeat (n) begin
      @(negedge clk);
      ce8 = 1'b1; iv8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
    end
  endtask

  initial begin
    #3 clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ov4", 32'(ov4), 32'd0);
    check("rst_out4", 32'(out4), 32'd0);
    check("rst_ov8", 32'(ov8), 32'd0);
    check("rst_out8", 32'(out8), 32'd0);
`ifdef MUL_ADDTREE_ACC_EN
    check("rst_acc4", 32'(acc4), 32'd0);
`endif
    #1 clr = 1'b1;
    idle4(2);

    // Single pulse at the maximum operands.
    send4(4'd15, 4'd15, 16'd225, 0);
    idle4(4);

    // Back-to-back stream.
    send4(4'd3, 4'd5, 16'd15, 0);
    send4(4'd0, 4'd9, 16'd0, 0);
    send4(4'd15, 4'd1, 16'd15, 0);
    send4(4'd10, 4'd10, 16'd100, 0);
    idle4(4);

    // W=8 instance.
    send8(8'd255, 8'd255, 16'd65025);
    idle8(1);
    send8(8'd128, 8'd2, 16'd256);
    idle8(5);

    // Stall: (7,6) is in flight while ce is low for 3 edges. The junk
    // operands presented during the stall must be ignored.
    send4(4'd5, 4'd5, 16'd25, 0);
    send4(4'd7, 4'd6, 16'd42, 3);
    @(negedge clk);
    ce4 = 1'b0; iv4 = 1'b1; x4 = 4'd13; y4 = 4'd11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ov4_held", 32'(ov4), 32'd1);
      check("stall_out4_held", 32'(out4), 32'd25);
      if (k == 2) begin
        ce4 = 1'b1; iv4 = 1'b0;
      end
    end
    idle4(4);

    // Reset mid-flight: the (9,9) beat is delivered, then reset discards (2,3).
    send4(4'd9, 4'd9, 16'd81, 0);
    @(negedge clk);
    ce4 = 1'b1; iv4 = 1'b1; x4 = 4'd2; y4 = 4'd3;
    @(negedge clk);
    iv4 = 1'b0;
    #1 clr = 1'b0;
    #1;
    check("clr_ov4_now", 32'(ov4), 32'd0);
    check("clr_out4_now", 32'(out4), 32'd0);
    check("clr_ov8_now", 32'(ov8), 32'd0);
    repeat (2) @(negedge clk);
    check("clr_ov4_held", 32'(ov4), 32'd0);
    check("clr_out4_held", 32'(out4), 32'd0);
    #1 clr = 1'b1;
    idle4(6);

`ifdef MUL_ADDTREE_ACC_EN
    // Accumulate four (15,15) beats with acc_clr on the first beat.
    // Then restart on a (2,2) beat.
    idle4(2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("acc4", 32'(acc4), 32'(acc_exp[k]));
      ce4      = 1'b1;
      iv4      = (k < 4) || (k == 6);
      x4       = (k < 4) ? 4'd15 : 4'd2;
      y4       = (k < 4) ? 4'd15 : 4'd2;
      acc_clr4 = (k == 2) || (k == 8);
      if (iv4) q4.push_back('{val: (k < 4) ? 16'd225 : 16'd4, due: cyc + LAT4});
    end
    acc_clr4 = 1'b0;
    idle4(3);
    check("acc4_hold", 32'(acc4), 32'd4);
`endif

    idle4(4);
    idle8(1);
    check("w4_queue_drained", 32'(q4.size()), 32'd0);
    check("w8_queue_drained", 32'(q8.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
